// File: rtl/hsv_adjust_pipe.sv
// HSV correction stage: hue rotation with wrap, S/V relative gains with clamp,
// valid/ready streaming, frame-synchronous shadowed control and bypass.
module hsv_adjust_pipe #(
  parameter int          HW      = 25,
  parameter int          SW      = 18,
  parameter int          FRAC    = 16,
  parameter int unsigned HUE_MAX = 360 << FRAC
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 IN_SOF,
  input  logic [HW-1:0]        H,
  input  logic [SW-1:0]        S,
  input  logic [SW-1:0]        V,
  input  logic                 CNTL_WR,
  input  logic signed [HW:0]   CNTL_HUE,
  input  logic signed [SW-1:0] CNTL_SAT,
  input  logic signed [SW-1:0] CNTL_VAL,
  input  logic                 CNTL_BYP,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_SOF,
  output logic [HW-1:0]        HO,
  output logic [SW-1:0]        SO,
  output logic [SW-1:0]        VO
);

  localparam logic [HW:0]          HMAX    = HUE_MAX[HW:0];
  localparam int unsigned          HLAST_I = HUE_MAX - 1;
  localparam logic [HW-1:0]        HLAST   = HLAST_I[HW-1:0];
  localparam logic signed [SW+1:0] ONE_X   = (SW+2)'(1 << FRAC);

  typedef struct packed {
    logic [HW-1:0] hue;
    logic [SW-1:0] sat;
    logic [SW-1:0] val;
    logic          byp;
  } cntl_t;

  function automatic logic [SW-1:0] clamp_unit(input logic signed [SW+1:0] x);
    if (x < 0)
      return '0;
    else if (x >= ONE_X)
      return ONE_X[SW-1:0];
    else
      return x[SW-1:0];
  endfunction

  logic  stall, accept, take, pend_flag;
  logic  [HW:0] hue_norm;
  cntl_t wr_set, pend, act, use_set;

  assign stall    = OUT_VALID & ~OUT_READY;
  assign IN_READY = ~stall;
  assign accept   = IN_VALID & ~stall;
  assign take     = accept & IN_SOF & (pend_flag | CNTL_WR);

  // A write coinciding with the SOF beat goes straight through to that beat.
  always_comb begin
    hue_norm = CNTL_HUE;
    if (CNTL_HUE[HW])
      hue_norm = CNTL_HUE + HMAX;
    wr_set = '{hue: hue_norm[HW-1:0], sat: CNTL_SAT, val: CNTL_VAL, byp: CNTL_BYP};
    use_set = act;
    if (take)
      use_set = CNTL_WR ? wr_set : pend;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend      <= '0;
      act       <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (CNTL_WR)
        pend <= wr_set;
      if (take) begin
        act       <= use_set;
        pend_flag <= 1'b0;
      end else if (CNTL_WR) begin
        pend_flag <= 1'b1;
      end
    end
  end

  // Stage 1 combinational: hue clamp/add, S/V products.
  logic [HW-1:0]        h_cl;
  logic [HW:0]          hsum_d;
  logic signed [2*SW:0] s_ext, v_ext, gs_ext, gv_ext, ps_d, pv_d;

  always_comb begin
    h_cl   = ({1'b0, H} >= HMAX) ? HLAST : H;
    hsum_d = use_set.byp ? {1'b0, H} : ({1'b0, h_cl} + {1'b0, use_set.hue});
    s_ext  = {{SW{1'b0}}, S};
    v_ext  = {{SW{1'b0}}, V};
    gs_ext = {{(SW+1){use_set.sat[SW-1]}}, use_set.sat};
    gv_ext = {{(SW+1){use_set.val[SW-1]}}, use_set.val};
    ps_d   = s_ext * gs_ext;
    pv_d   = v_ext * gv_ext;
  end

  logic                 s1_vld, s1_sof, s1_byp;
  logic [HW:0]          s1_hsum;
  logic [SW-1:0]        s1_s, s1_v;
  logic signed [SW+1:0] s1_ps, s1_pv;

  logic                 s2_vld, s2_sof, s2_byp;
  logic [HW-1:0]        s2_hue;
  logic signed [SW+1:0] s2_s, s2_v;

  logic [HW:0]          hue2;
  logic signed [SW+1:0] sres, vres;

  // Stage 2 combinational: hue reduction and gain application.
  always_comb begin
    hue2 = s1_hsum;
    if (!s1_byp && (s1_hsum >= HMAX))
      hue2 = s1_hsum - HMAX;
    sres = {2'b00, s1_s};
    vres = {2'b00, s1_v};
    if (!s1_byp) begin
      sres = $signed({2'b00, s1_s}) + s1_ps;
      vres = $signed({2'b00, s1_v}) + s1_pv;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{hue_norm[HW], hue2[HW],
                         ps_d[2*SW:FRAC+SW+2], ps_d[FRAC-1:0],
                         pv_d[2*SW:FRAC+SW+2], pv_d[FRAC-1:0]};

  // The floor shift by FRAC is folded into the stage-1 bit selection of the product.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld    <= 1'b0;
      s1_sof    <= 1'b0;
      s1_byp    <= 1'b0;
      s1_hsum   <= '0;
      s1_s      <= '0;
      s1_v      <= '0;
      s1_ps     <= '0;
      s1_pv     <= '0;
      s2_vld    <= 1'b0;
      s2_sof    <= 1'b0;
      s2_byp    <= 1'b0;
      s2_hue    <= '0;
      s2_s      <= '0;
      s2_v      <= '0;
      OUT_VALID <= 1'b0;
      OUT_SOF   <= 1'b0;
      HO        <= '0;
      SO        <= '0;
      VO        <= '0;
    end else if (!stall) begin
      s1_vld    <= accept;
      s1_sof    <= accept & IN_SOF;
      s1_byp    <= use_set.byp;
      s1_hsum   <= hsum_d;
      s1_s      <= S;
      s1_v      <= V;
      s1_ps     <= ps_d[FRAC+SW+1:FRAC];
      s1_pv     <= pv_d[FRAC+SW+1:FRAC];
      s2_vld    <= s1_vld;
      s2_sof    <= s1_sof;
      s2_byp    <= s1_byp;
      s2_hue    <= hue2[HW-1:0];
      s2_s      <= sres;
      s2_v      <= vres;
      OUT_VALID <= s2_vld;
      OUT_SOF   <= s2_sof;
      HO        <= s2_hue;
      SO        <= s2_byp ? s2_s[SW-1:0] : clamp_unit(s2_s);
      VO        <= s2_byp ? s2_v[SW-1:0] : clamp_unit(s2_v);
    end
  end

endmodule

// File: tb/tb_hsv_adjust_pipe.sv
// Directed bench for hsv_adjust_pipe: vector table plus hand sequences for
// shadowing, backpressure and mid-stream reset.
module tb_hsv_adjust_pipe;

  localparam int HW = 25;
  localparam int SW = 18;
  localparam int FRAC = 16;
  localparam int NB = 12;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 IN_VALID = 1'b0;
  logic                 IN_READY;
  logic                 IN_SOF = 1'b0;
  logic [HW-1:0]        H = '0;
  logic [SW-1:0]        S = '0;
  logic [SW-1:0]        V = '0;
  logic                 CNTL_WR = 1'b0;
  logic signed [HW:0]   CNTL_HUE = '0;
  logic signed [SW-1:0] CNTL_SAT = '0;
  logic signed [SW-1:0] CNTL_VAL = '0;
  logic                 CNTL_BYP = 1'b0;
  logic                 OUT_VALID;
  logic                 OUT_READY = 1'b1;
  logic                 OUT_SOF;
  logic [HW-1:0]        HO;
  logic [SW-1:0]        SO;
  logic [SW-1:0]        VO;

  int n_checks = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  hsv_adjust_pipe #(.HW(HW), .SW(SW), .FRAC(FRAC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SOF(IN_SOF),
    .H(H), .S(S), .V(V),
    .CNTL_WR(CNTL_WR), .CNTL_HUE(CNTL_HUE), .CNTL_SAT(CNTL_SAT),
    .CNTL_VAL(CNTL_VAL), .CNTL_BYP(CNTL_BYP),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SOF(OUT_SOF),
    .HO(HO), .SO(SO), .VO(VO)
  );

  typedef struct {
    logic                 wr;
    logic signed [HW:0]   hue;
    logic signed [SW-1:0] sat;
    logic signed [SW-1:0] val;
    logic                 byp;
    logic                 sof;
    logic [HW-1:0]        h;
    logic [SW-1:0]        s;
    logic [SW-1:0]        v;
    logic [HW-1:0]        eho;
    logic [SW-1:0]        eso;
    logic [SW-1:0]        evo;
  } vec_t;

  vec_t vecs[NB];
  vec_t cur;

  function automatic vec_t mkv(input logic wr, input logic signed [HW:0] hue,
                               input logic signed [SW-1:0] sat, input logic signed [SW-1:0] val,
                               input logic byp, input logic sof,
                               input logic [HW-1:0] h, input logic [SW-1:0] s, input logic [SW-1:0] v,
                               input logic [HW-1:0] eho, input logic [SW-1:0] eso,
                               input logic [SW-1:0] evo);
    vec_t r;
    r.wr = wr; r.hue = hue; r.sat = sat; r.val = val; r.byp = byp; r.sof = sof;
    r.h = h; r.s = s; r.v = v; r.eho = eho; r.eso = eso; r.evo = evo;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_cntl(input vec_t v);
    CNTL_HUE = v.hue;
    CNTL_SAT = v.sat;
    CNTL_VAL = v.val;
    CNTL_BYP = v.byp;
  endtask

  task automatic cntl_write(input vec_t v);
    set_cntl(v);
    CNTL_WR = 1'b1;
    @(posedge CLK); #1;
    CNTL_WR = 1'b0;
  endtask

  // One isolated beat; expects the result exactly 3 cycles after acceptance.
  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    set_cntl(v);
    CNTL_WR  = v.wr;
    IN_VALID = 1'b1;
    IN_SOF   = v.sof;
    H = v.h; S = v.s; V = v.v;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    CNTL_WR  = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 10) begin
      @(posedge CLK); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd3);
    chk({tag, "_ho"}, 32'(HO), 32'(v.eho));
    chk({tag, "_so"}, 32'(SO), 32'(v.eso));
    chk({tag, "_vo"}, 32'(VO), 32'(v.evo));
    chk({tag, "_sof"}, 32'(OUT_SOF), 32'(v.sof));
    @(posedge CLK); #1;
  endtask

  int drv_i, drv_cyc, mon_cyc, rx, stall_cnt;
  logic drv_acc, prev_stall;
  logic [HW-1:0] held_h;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            wr  hue            sat            val           byp  sof  h             s          v          eho           eso        evo
    vecs[0]  = mkv(0, 26'sd0,        18'sd0,        18'sd0,       0,   1,   25'h0B40000, 18'h08000, 18'h10000, 25'h0B40000, 18'h08000, 18'h10000);
    vecs[1]  = mkv(1, 26'sh5A0000,   18'sd0,        18'sd0,       0,   1,   25'h12C0000, 18'h08000, 18'h08000, 25'h01E0000, 18'h08000, 18'h08000);
    vecs[2]  = mkv(1, -26'sh5A0000,  18'sd0,        18'sd0,       0,   1,   25'h01E0000, 18'h08000, 18'h08000, 25'h12C0000, 18'h08000, 18'h08000);
    vecs[3]  = mkv(1, 26'sd0,        18'sd0,        18'sd0,       0,   1,   25'h1700000, 18'h08000, 18'h08000, 25'h167FFFF, 18'h08000, 18'h08000);
    vecs[4]  = mkv(1, 26'sd0,        18'sh10000,    18'sd0,       0,   1,   25'h0000000, 18'h0C000, 18'h04000, 25'h0000000, 18'h10000, 18'h04000);
    vecs[5]  = mkv(1, 26'sd0,        -18'sh18000,   18'sd0,       0,   1,   25'h0000000, 18'h08000, 18'h04000, 25'h0000000, 18'h00000, 18'h04000);
    vecs[6]  = mkv(1, 26'sd0,        18'sd0,        18'sh08000,   0,   1,   25'h0000000, 18'h08000, 18'h08000, 25'h0000000, 18'h08000, 18'h0C000);
    vecs[7]  = mkv(1, 26'sd0,        18'sh10000,    18'sh08000,   1,   1,   25'h1700000, 18'h30000, 18'h3FFFF, 25'h1700000, 18'h30000, 18'h3FFFF);
    vecs[8]  = mkv(1, 26'sd0,        18'sd0,        18'sd0,       0,   1,   25'h0000100, 18'h10000, 18'h20000, 25'h0000100, 18'h10000, 18'h10000);
    vecs[9]  = mkv(1, 26'sh1000,     18'sd0,        18'sd0,       0,   0,   25'h0100000, 18'h04000, 18'h04000, 25'h0100000, 18'h04000, 18'h04000);
    vecs[10] = mkv(0, 26'sd0,        18'sd0,        18'sd0,       0,   1,   25'h0100000, 18'h04000, 18'h04000, 25'h0101000, 18'h04000, 18'h04000);
    vecs[11] = mkv(0, 26'sd0,        18'sd0,        18'sd0,       0,   0,   25'h167F000, 18'h04000, 18'h04000, 25'h0000000, 18'h04000, 18'h04000);

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset_out_sof", 32'(OUT_SOF), 32'd0);
    chk("reset_ho", 32'(HO), 32'd0);
    chk("reset_so", 32'(SO), 32'd0);
    chk("reset_vo", 32'(VO), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd1);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < NB; i++)
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Mid-frame write is held until the next SOF beat.
    cntl_write(mkv(1, 26'sd0, 18'sd0, 18'sd0, 0, 0, '0, '0, '0, '0, '0, '0));
    run_vec("shd_sof0", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 1, 25'h0, 18'h04000, 18'h04000, 25'h0, 18'h04000, 18'h04000));
    cntl_write(mkv(1, 26'sd0, 18'sh10000, 18'sd0, 0, 0, '0, '0, '0, '0, '0, '0));
    run_vec("shd_mid", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 0, 25'h0, 18'h04000, 18'h04000, 25'h0, 18'h04000, 18'h04000));
    run_vec("shd_sof1", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 1, 25'h0, 18'h04000, 18'h04000, 25'h0, 18'h08000, 18'h04000));
    run_vec("shd_next", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 0, 25'h0, 18'h03000, 18'h04000, 25'h0, 18'h06000, 18'h04000));

    // Last write before SOF wins.
    cntl_write(mkv(1, 26'sd0, 18'sh10000, 18'sd0, 0, 0, '0, '0, '0, '0, '0, '0));
    cntl_write(mkv(1, 26'sd0, 18'sd0, 18'sh08000, 0, 0, '0, '0, '0, '0, '0, '0));
    run_vec("last_wins", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 1, 25'h0, 18'h08000, 18'h08000, 25'h0, 18'h08000, 18'h0C000));

    // Backpressure: continuous stream with OUT_READY low for 4 cycles.
    cntl_write(mkv(1, 26'sd0, 18'sd0, 18'sd0, 0, 0, '0, '0, '0, '0, '0, '0));
    drv_i = 0; drv_cyc = 0; mon_cyc = 0; rx = 0; stall_cnt = 0; prev_stall = 1'b0; held_h = '0;
    fork
      begin
        while (drv_i < NB && drv_cyc < 200) begin
          IN_VALID = 1'b1;
          IN_SOF   = (drv_i == 0);
          H = HW'(drv_i * 65536);
          S = SW'(drv_i * 256 + 1);
          V = SW'(drv_i * 512);
          @(negedge CLK);
          drv_acc = IN_READY;
          @(posedge CLK); #1;
          drv_cyc++;
          if (drv_acc) drv_i++;
        end
        IN_VALID = 1'b0;
        IN_SOF   = 1'b0;
      end
      begin
        repeat (6) @(posedge CLK);
        #1 OUT_READY = 1'b0;
        repeat (4) @(posedge CLK);
        #1 OUT_READY = 1'b1;
      end
      begin
        while (rx < NB && mon_cyc < 200) begin
          @(negedge CLK);
          mon_cyc++;
          chk("bp_in_ready", 32'(IN_READY), 32'(OUT_READY));
          if (!IN_READY) stall_cnt++;
          if (prev_stall) chk("bp_hold_ho", 32'(HO), 32'(held_h));
          if (OUT_VALID && OUT_READY) begin
            chk($sformatf("bp_ho%0d", rx), 32'(HO), 32'(rx * 65536));
            chk($sformatf("bp_so%0d", rx), 32'(SO), 32'(rx * 256 + 1));
            chk($sformatf("bp_vo%0d", rx), 32'(VO), 32'(rx * 512));
            chk($sformatf("bp_sof%0d", rx), 32'(OUT_SOF), 32'(rx == 0));
            rx++;
          end
          prev_stall = OUT_VALID && !OUT_READY;
          held_h = HO;
        end
      end
    join
    chk("bp_beat_count", 32'(rx), 32'(NB));
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd4);
    @(posedge CLK); #1;
    chk("bp_drained", 32'(OUT_VALID), 32'd0);

    // Reset with three beats in flight under a non-identity hue offset.
    cntl_write(mkv(1, 26'sh5A0000, 18'sd0, 18'sd0, 0, 0, '0, '0, '0, '0, '0, '0));
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1;
      IN_SOF   = (k == 0);
      H = 25'h0100000; S = 18'h08000; V = 18'h08000;
      @(posedge CLK); #1;
    end
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    chk("rst_pre_valid", 32'(OUT_VALID), 32'd1);
    chk("rst_pre_ho", 32'(HO), 32'h06A0000);
    RST_N = 1'b0;
    #1;
    chk("rst_async_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_async_ho", 32'(HO), 32'd0);
    chk("rst_async_so", 32'(SO), 32'd0);
    chk("rst_async_vo", 32'(VO), 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_no_stale", 32'(OUT_VALID), 32'd0);
    run_vec("post_rst", mkv(0, 26'sd0, 18'sd0, 18'sd0, 0, 0, 25'h12C0000, 18'h08000, 18'h08000, 25'h12C0000, 18'h08000, 18'h08000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hsv_adjust_pipe.md
Name: hsv_adjust_pipe

Overview:
- Parametrised, streaming successor to the fixed-width HSV correction stage.
- Applies a hue rotation with wrap, and saturation/value relative gains with clamping, to one HSV pixel per beat.
- Adds valid/ready flow control, frame-synchronous shadowed control registers and a bypass mode.
- Sits between the RGB->HSV converter and the HSV->RGB converter in the video path.

Parameters:
- HW, 25, hue width; unsigned fixed point, FRAC fractional bits, in degrees.
- SW, 18, saturation/value width; unsigned, ONE = 1<<FRAC.
- FRAC, 16, fractional bits shared by hue, S, V and gains.
- HUE_MAX, 360<<FRAC (0x1680000), hue modulus.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  input beat valid.
- IN_READY  out  1  block accepts beat when IN_VALID & IN_READY.
- IN_SOF  in  1  beat is first pixel of frame.
- H  in  HW  hue.
- S  in  SW  saturation.
- V  in  SW  value.
- CNTL_WR  in  1  one-cycle strobe; loads pending control set.
- CNTL_HUE  in  HW+1  signed hue offset; |x| < HUE_MAX.
- CNTL_SAT  in  SW  signed saturation gain, FRAC fractional bits.
- CNTL_VAL  in  SW  signed value gain, FRAC fractional bits.
- CNTL_BYP  in  1  bypass request.
- OUT_VALID  out  1  output beat valid.
- OUT_READY  in  1  downstream accepts.
- OUT_SOF  out  1  SOF aligned with output beat.
- HO  out  HW  hue out.
- SO  out  SW  saturation out.
- VO  out  SW  value out.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All pipeline valids = 0; OUT_VALID = 0, OUT_SOF = 0, HO/SO/VO = 0.
  - Pending and active control = identity (offset 0, gains 0, bypass 0); pending_flag = 0.
  - Reset mid-frame drops every in-flight beat. The first beat after reset uses identity control.
- Pipeline and flow control:
  - 3 register stages; latency 3 cycles from acceptance to OUT_VALID when not stalled.
  - stall = OUT_VALID & ~OUT_READY. IN_READY = ~stall, combinational.
  - All stages hold while stalled; bubbles are not collapsed.
  - No beat is lost, duplicated or reordered.
  - Outputs hold stable while OUT_VALID & ~OUT_READY.
- Control shadowing:
  - CNTL_WR: the pending set captures CNTL_* and pending_flag is set.
  - CNTL_HUE is normalised on capture: a negative value gets HUE_MAX added, so the pending offset is in [0, HUE_MAX).
  - On an accepted beat with IN_SOF = 1 and pending_flag = 1: pending is copied to active and the flag is cleared. That beat and all later beats use the new set.
  - CNTL_WR in the same cycle as an accepted SOF beat: write-through, and the SOF beat uses the just-written values.
  - CNTL_WR while no SOF arrives: pending only; active is unchanged.
  - A repeated CNTL_WR before SOF overwrites pending; last write wins.
  - Active control is sampled per beat at stage 1 and travels with the beat, so later control changes never affect in-flight beats.
- Stage 1:
  - H >= HUE_MAX is clamped to HUE_MAX-1.
  - hsum = H + off, HW+1 bits.
  - ps = S*gain_s and pv = V*gain_v, signed, 2*SW+1 bits.
  - Register SOF and the bypass bit.
- Stage 2:
  - hue = hsum >= HUE_MAX ? hsum - HUE_MAX : hsum.
  - sres = S + (ps >>> FRAC), arithmetic shift (floor), SW+2 bits signed; vres likewise.
- Stage 3:
  - Clamp: negative -> 0; >= ONE -> ONE; else unchanged.
  - HO = hue[HW-1:0].
- Bypass: when the beat's bypass bit = 1, HO/SO/VO = H/S/V unmodified (no clamp, no hue reduction), with the same latency and handshake.

Test Plan:
- Identity: reset, no CNTL_WR, H=0x0B40000, S=0x8000, V=0x10000 -> HO/SO/VO identical 3 cycles later; OUT_SOF follows IN_SOF.
- Hue wrap: CNTL_HUE=+0x5A0000 then SOF beat, H=0x12C0000 -> HO=0x1E0000. CNTL_HUE=-0x5A0000, H=0x1E0000 -> HO=0x12C0000. H=0x1700000 with offset 0 -> HO=0x167FFFF.
- Gain/clamp:
  - CNTL_SAT=0x10000, S=0xC000 -> SO=0x10000.
  - CNTL_SAT=-0x18000, S=0x8000 -> SO=0.
  - CNTL_VAL=0x08000, V=0x8000 -> VO=0xC000.
- Shadowing: CNTL_WR (sat gain 0x10000) mid-frame -> remaining beats unchanged; next SOF beat and followers doubled. CNTL_WR coincident with SOF beat -> that beat already uses new gain.
- Backpressure: continuous input, OUT_READY low for 4 cycles mid-stream -> IN_READY low exactly while OUT_VALID & ~OUT_READY; output sequence equals input sequence, no gaps lost, no duplicates.
- Reset mid-stream: assert RST_N low with 3 beats in flight -> outputs 0 immediately, OUT_VALID=0; after release, next beat processed with identity control.
